// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests and buffers {pc, instr} for ID.
// Optional IF_MISALIGN_CHECK_EN turns a misaligned redirect target into a held fault entry.
`ifndef NEW_PC
`define NEW_PC 1'b1
`endif
`ifndef PC_PLUS4
`define PC_PLUS4 1'b0
`endif

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [31:0] new_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = 8;
    localparam logic [CW:0] DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic [DW-1:0] drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   fifo_ins [FIFO_DEPTH];
    logic [31:0]   pcq_mem  [FIFO_DEPTH];

    logic          redirect;
    logic          has_credit;
    logic          accept;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          fault_hold;
    logic          bad_target;
    logic [31:0]   target_pc;

`ifdef IF_MISALIGN_CHECK_EN
    logic fifo_mis [FIFO_DEPTH];
    logic fault_q;

    assign bad_target = (new_pc[1:0] != 2'b00);
    assign target_pc  = new_pc;
    assign fault_hold = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= bad_target;
        end
    end

    always_ff @(posedge clk) begin
        if (redirect && bad_target) begin
            fifo_mis[0] <= 1'b1;
        end else if (push) begin
            fifo_mis[wr_ptr] <= 1'b0;
        end
    end

    assign if_misalign = if_valid && fifo_mis[rd_ptr];
`else
    assign bad_target  = 1'b0;
    assign target_pc   = {new_pc[31:2], 2'b00};
    assign fault_hold  = 1'b0;
    assign if_misalign = 1'b0;
`endif

    // Credit counts buffered plus in-flight entries; responses being dropped hold no slot.
    assign redirect   = (pc_src == `NEW_PC);
    assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_W;
    assign imem_req_valid = !rst && !stall && has_credit && !redirect && !fault_hold;
    assign imem_req_addr  = pc;
    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_drop = (drop != '0);
    assign push     = imem_rsp_valid && !rsp_drop && !redirect;
    assign pop      = if_valid && if_ready && !stall && !redirect;

    assign if_valid = (fifo_count != '0);
    assign if_pc    = if_valid ? fifo_pc[rd_ptr]  : 32'h0;
    assign if_instr = if_valid ? fifo_ins[rd_ptr] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            fifo_count <= '0;
            inflight   <= '0;
            drop       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
        end else if (redirect) begin
            // Everything still outstanding, plus a response landing now, is wrong-path.
            pc       <= target_pc;
            drop     <= drop + DW'(inflight) + DW'(accept) - DW'(imem_rsp_valid);
            inflight <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            rd_ptr   <= '0;
            if (bad_target) begin
                fifo_count <= CW'(1);
                wr_ptr     <= AW'(1);
            end else begin
                fifo_count <= '0;
                wr_ptr     <= '0;
            end
        end else begin
            if (accept) begin
                pc     <= pc + 32'd4;
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (push) begin
                pcq_rd <= pcq_rd + AW'(1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (imem_rsp_valid && rsp_drop) begin
                drop <= drop - DW'(1);
            end
            inflight   <= inflight + CW'(accept) - CW'(push);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr] <= pc;
        end
        if (redirect && bad_target) begin
            fifo_pc[0]  <= new_pc;
            fifo_ins[0] <= NOP_INSTR;
        end else if (push) begin
            fifo_pc[wr_ptr]  <= pcq_mem[pcq_rd];
            fifo_ins[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model (data = addr + 0x1000_0000).
module tb_if_fetch_unit;
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    int   total = 0;
    int   bad = 0;
    logic mem_hold = 1'b0;
    wq_t  memq;
    wq_t  acc_log;
    wq_t  pop_pc;
    wq_t  pop_ins;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .new_pc(new_pc), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input wq_t q, input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock: log handshakes, advance the edge, then present the next memory response.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (acc) acc_log.push_back(a);
        if (if_valid && if_ready && !stall && pc_src == 1'b0) begin
            pop_pc.push_back(if_pc);
            pop_ins.push_back(if_instr);
        end
        @(posedge clk);
        #1;
        if (acc) memq.push_back(a);
        imem_rsp_valid = 1'b0;
        if (!mem_hold && memq.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq.pop_front() + 32'h1000_0000;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_pc.delete();
        pop_ins.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_src = 1'b0;
        new_pc = 32'h0;
        stall = 1'b0;
        mem_hold = 1'b0;
        imem_rsp_valid = 1'b0;
        memq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        pc_src = 1'b1;
        new_pc = tgt;
        #1;
        check("no_issue_in_redirect", imem_req_valid, 1'b0);
        cyc();
        pc_src = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset values, first-request latency, in-order sequential fetch
        @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_misalign", if_misalign, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, 32'h0);
        cyc();
        check("rsp_cycle_if_valid", if_valid, 1'b0);
        cyc();
        check("head_valid", if_valid, 1'b1);
        check("head_pc", if_pc, 32'h0);
        check("head_instr", if_instr, 32'h1000_0000);
        repeat (8) cyc();
        check("t1_acc0", qat(acc_log, 0), 32'h0);
        check("t1_acc1", qat(acc_log, 1), 32'h4);
        check("t1_acc2", qat(acc_log, 2), 32'h8);
        check("t1_pop0", qat(pop_pc, 0), 32'h0);
        check("t1_pop1", qat(pop_pc, 1), 32'h4);
        check("t1_pop2", qat(pop_pc, 2), 32'h8);
        check("t1_ins2", qat(pop_ins, 2), 32'h1000_0008);

        // 2: ID backpressure fills the buffer, credit stops issue
        do_reset();
        if_ready = 1'b0;
        repeat (6) cyc();
        check("t2_acc_count", acc_log.size(), 32'd2);
        check("t2_req_blocked", imem_req_valid, 1'b0);
        check("t2_head_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        repeat (6) cyc();
        check("t2_resume_addr", qat(acc_log, 2), 32'h8);
        check("t2_pop0", qat(pop_pc, 0), 32'h0);
        check("t2_pop1", qat(pop_pc, 1), 32'h4);

        // 3: redirect with two requests in flight
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cyc();
        check("t3_inflight_acc", acc_log.size(), 32'd2);
        redirect_to(32'h100);
        mem_hold = 1'b0;
        repeat (10) cyc();
        check("t3_acc0", qat(acc_log, 0), 32'h100);
        check("t3_pop0", qat(pop_pc, 0), 32'h100);
        check("t3_ins0", qat(pop_ins, 0), 32'h1000_0100);
        check("t3_pop1", qat(pop_pc, 1), 32'h104);

        // 4: redirect in the same cycle a wrong-path response arrives
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cyc();
        mem_hold = 1'b0;
        cyc();
        redirect_to(32'h200);
        repeat (10) cyc();
        check("t4_acc0", qat(acc_log, 0), 32'h200);
        check("t4_pop0", qat(pop_pc, 0), 32'h200);
        check("t4_ins0", qat(pop_ins, 0), 32'h1000_0200);
        check("t4_pop1", qat(pop_pc, 1), 32'h204);

        // 5: stall holds the head and blocks issue; redirect still lands
        do_reset();
        repeat (2) cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_stall_noreq", imem_req_valid, 1'b0);
            check("t5_stall_pc", if_pc, 32'h0);
        end
        redirect_to(32'h300);
        #1;
        check("t5_flushed", if_valid, 1'b0);
        check("t5_stall_credit_noreq", imem_req_valid, 1'b0);
        stall = 1'b0;
        repeat (8) cyc();
        check("t5_acc0", qat(acc_log, 0), 32'h300);
        check("t5_pop0", qat(pop_pc, 0), 32'h300);

`ifdef IF_MISALIGN_CHECK_EN
        // 6: misaligned target parks a fault entry until the next redirect
        do_reset();
        if_ready = 1'b0;
        repeat (3) cyc();
        redirect_to(32'h102);
        repeat (4) cyc();
        check("t6_fault_valid", if_valid, 1'b1);
        check("t6_fault_flag", if_misalign, 1'b1);
        check("t6_fault_instr", if_instr, 32'h13);
        check("t6_fault_pc", if_pc, 32'h102);
        check("t6_fault_noacc", acc_log.size(), 32'd0);
        if_ready = 1'b1;
        cyc();
        check("t6_fault_popped", if_valid, 1'b0);
        repeat (3) cyc();
        check("t6_still_held", acc_log.size(), 32'd0);
        redirect_to(32'h400);
        repeat (6) cyc();
        check("t6_recover_pop", qat(pop_pc, 0), 32'h400);
`else
        // 6: misaligned target is forced to word alignment
        do_reset();
        repeat (3) cyc();
        redirect_to(32'h102);
        repeat (8) cyc();
        check("t6_align_acc", qat(acc_log, 0), 32'h100);
        check("t6_align_pop", qat(pop_pc, 0), 32'h100);
        check("t6_no_misalign", if_misalign, 1'b0);
`endif

        // reset asserted mid-burst clears outputs immediately
        do_reset();
        if_ready = 1'b0;
        repeat (2) cyc();
        check("mid_pre_valid", if_valid, 1'b1);
        check("mid_pre_pc", if_pc, 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_req", imem_req_valid, 1'b0);
        check("mid_rst_valid", if_valid, 1'b0);
        check("mid_rst_pc", if_pc, 32'h0);
        check("mid_rst_instr", if_instr, 32'h0);
        check("mid_rst_misalign", if_misalign, 1'b0);
        do_reset();
        #1;
        check("mid_restart_addr", imem_req_addr, 32'h0);
        check("mid_restart_req", imem_req_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
